// File: rtl/sm_run_ctrl_pkg.sv
// Shared command codes and FSM state encoding for the debug run/step controller.
package sm_run_ctrl_pkg;

  localparam logic [1:0] CMD_HALT   = 2'd0;
  localparam logic [1:0] CMD_RUN    = 2'd1;
  localparam logic [1:0] CMD_STEP   = 2'd2;
  localparam logic [1:0] CMD_RUN_BP = 2'd3;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_RUN_BP = 2'd3
  } state_t;

endpackage

// File: rtl/sm_tick_gen.sv
// Rate tick generator: tick asserts once every 2^devide clk cycles while running.
module sm_tick_gen #(
  parameter int CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       hold,
  input  logic [3:0] devide,
  output logic       tick
);

  logic [CNT_WIDTH-1:0] tick_cnt;
  logic [CNT_WIDTH-1:0] limit;

  assign limit = (CNT_WIDTH'(1) << devide) - CNT_WIDTH'(1);
  // >= rather than == so lowering devide mid-period still fires promptly
  assign tick  = (tick_cnt >= limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (clear || hold || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sm_run_ctrl.sv
// Debug run/step controller: paces the CPU with a cpuEn pulse stream and
// stops on HALT, step-count exhaustion or a breakpoint address match.
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // cmdValid is a strobe with no ready: every cycle it is high, the command
  // on cmdCode/cmdCount/bpAddr is taken at that clk edge, in any state.
  input  logic                  cmdValid,
  input  logic [1:0]            cmdCode,
  input  logic [CNT_WIDTH-1:0]  cmdCount,
  input  logic [ADDR_WIDTH-1:0] bpAddr,
  input  logic [3:0]            devide,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  cpuEn,
  output logic                  halted,
  output logic                  doneStrb,
  output logic                  bpHit,
  output logic [CNT_WIDTH-1:0]  execCnt,
  output state_t                dbg_state
);

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] remaining, remaining_n;
  logic [CNT_WIDTH-1:0] exec_n;
  logic                 bp_hit_n, done_n;
  logic                 active, tick, bp_stop;

  sm_tick_gen #(.CNT_WIDTH(CNT_WIDTH)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cmdValid),
    .hold   (state == ST_HALTED),
    .devide (devide),
    .tick   (tick)
  );

  assign active    = (state != ST_HALTED);
  // execCnt != 0 lets a run that starts on the breakpoint step through it once
  assign bp_stop   = (state == ST_RUN_BP) && (pc == bpAddr) && (execCnt != '0);
  assign cpuEn     = active && tick && !bp_stop;
  assign halted    = (state == ST_HALTED);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HALTED;
      remaining <= '0;
      execCnt   <= '0;
      bpHit     <= 1'b0;
      doneStrb  <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      execCnt   <= exec_n;
      bpHit     <= bp_hit_n;
      doneStrb  <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    exec_n      = execCnt;
    bp_hit_n    = bpHit;
    done_n      = 1'b0;
    if (cpuEn && (execCnt != '1)) exec_n = execCnt + CNT_WIDTH'(1);

    if (cmdValid) begin
      // A command overrides any internal termination in the same cycle
      exec_n   = '0;
      bp_hit_n = 1'b0;
      case (cmdCode)
        CMD_HALT: begin
          state_n = ST_HALTED;
          done_n  = active;
        end
        CMD_RUN:  state_n = ST_RUN;
        CMD_STEP: begin
          remaining_n = cmdCount;
          if (cmdCount == '0) begin
            state_n = ST_HALTED;
            done_n  = 1'b1;
          end else begin
            state_n = ST_STEP;
          end
        end
        default:  state_n = ST_RUN_BP;
      endcase
    end else begin
      case (state)
        ST_STEP: begin
          if (cpuEn) begin
            remaining_n = remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              state_n = ST_HALTED;
              done_n  = 1'b1;
            end
          end
        end
        ST_RUN_BP: begin
          if (bp_stop) begin
            state_n  = ST_HALTED;
            bp_hit_n = 1'b1;
            done_n   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
